// File: rtl/game_pkg.sv
// Shared types for the two-player battleship game controller: FSM state
// encoding, first-attacker selection and small state-decode helpers.
package game_pkg;

  typedef enum logic [3:0] {
    S_PLACE   = 4'd0,
    S_TURN_A  = 4'd1,
    S_HIT_A   = 4'd2,
    S_CHECK_A = 4'd3,
    S_TURN_B  = 4'd4,
    S_HIT_B   = 4'd5,
    S_CHECK_B = 4'd6,
    S_WIN_A   = 4'd7,
    S_WIN_B   = 4'd8,
    S_RESTART = 4'd9
  } state_e;

  localparam logic FIRST_TURN_A = 1'b0;
  localparam logic FIRST_TURN_B = 1'b1;

  // Ship-register source: switches while placing/restarting, damage feedback otherwise.
  function automatic logic st_of(input state_e s);
    logic st;
    case (s)
      S_PLACE:   st = 1'b0;
      S_RESTART: st = 1'b0;
      default:   st = 1'b1;
    endcase
    return st;
  endfunction

  function automatic state_e first_turn_state(input logic ft);
    return (ft == FIRST_TURN_B) ? S_TURN_B : S_TURN_A;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for one debounced button level.
module edge_detect (
  input  logic clk,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  // Previous level tracks the input every cycle, reset included, so a level
  // held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Battleship game sequencer: placement, alternating attacks, damage
// application, win display and restart. All outputs are registered.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic FIRST_TURN = FIRST_TURN_A
) (
  input  logic clk,
  input  logic clr,
  input  logic BTN1A,
  input  logic BTN1B,
  input  logic BTN2A,
  input  logic BTN2B,
  input  logic BTN3A,
  input  logic BTN3B,
  input  logic OKA,
  input  logic OKB,
  input  logic LivA,
  input  logic LivB,
  output logic LDR1A,
  output logic LDR1B,
  output logic LDR2A,
  output logic LDR2B,
  output logic ST,
  output logic DispA,
  output logic DispB,
  output logic TurnA,
  output logic TurnB,
  output logic clr_game
);

  logic   b1a_rise, b1b_rise, b2a_rise, b2b_rise, b3a_rise, b3b_rise;
  state_e state_q, state_d;
  logic   placed_a_q, placed_a_d, placed_b_q, placed_b_d;
  logic   ldr1a_q, ldr1a_d, ldr1b_q, ldr1b_d;
  logic   ldr2a_q, ldr2a_d, ldr2b_q, ldr2b_d;
  logic   st_q, disp_a_q, disp_b_q, turn_a_q, turn_b_q, clr_game_q;

  edge_detect u_ed_b1a (.clk(clk), .d_i(BTN1A), .rise_o(b1a_rise));
  edge_detect u_ed_b1b (.clk(clk), .d_i(BTN1B), .rise_o(b1b_rise));
  edge_detect u_ed_b2a (.clk(clk), .d_i(BTN2A), .rise_o(b2a_rise));
  edge_detect u_ed_b2b (.clk(clk), .d_i(BTN2B), .rise_o(b2b_rise));
  edge_detect u_ed_b3a (.clk(clk), .d_i(BTN3A), .rise_o(b3a_rise));
  edge_detect u_ed_b3b (.clk(clk), .d_i(BTN3B), .rise_o(b3b_rise));

  // Next-state and next load-enable decision for the game sequence.
  always_comb begin
    state_d    = state_q;
    placed_a_d = placed_a_q;
    placed_b_d = placed_b_q;
    ldr1a_d    = 1'b0;
    ldr1b_d    = 1'b0;
    ldr2a_d    = 1'b0;
    ldr2b_d    = 1'b0;
    case (state_q)
      S_PLACE: begin
        if (b1a_rise) begin
          ldr1a_d    = 1'b1;
          placed_a_d = 1'b1;
        end else begin
          ldr1a_d    = 1'b0;
        end
        if (b1b_rise) begin
          ldr1b_d    = 1'b1;
          placed_b_d = 1'b1;
        end else begin
          ldr1b_d    = 1'b0;
        end
        if (placed_a_d && placed_b_d) begin
          state_d = first_turn_state(FIRST_TURN);
        end else begin
          state_d = S_PLACE;
        end
      end
      S_TURN_A: begin
        if (b2a_rise && OKA) begin
          ldr2a_d = 1'b1;
          state_d = S_HIT_A;
        end else begin
          state_d = S_TURN_A;
        end
      end
      S_TURN_B: begin
        if (b2b_rise && OKB) begin
          ldr2b_d = 1'b1;
          state_d = S_HIT_B;
        end else begin
          state_d = S_TURN_B;
        end
      end
      S_HIT_A: begin
        ldr1b_d = 1'b1;
        state_d = S_CHECK_A;
      end
      S_HIT_B: begin
        ldr1a_d = 1'b1;
        state_d = S_CHECK_B;
      end
      S_CHECK_A: state_d = LivB ? S_TURN_B : S_WIN_A;
      S_CHECK_B: state_d = LivA ? S_TURN_A : S_WIN_B;
      S_WIN_A, S_WIN_B: begin
        if (b3a_rise || b3b_rise) begin
          state_d = S_RESTART;
        end else begin
          state_d = state_q;
        end
      end
      S_RESTART: begin
        placed_a_d = 1'b0;
        placed_b_d = 1'b0;
        state_d    = S_PLACE;
      end
      default: begin
        placed_a_d = 1'b0;
        placed_b_d = 1'b0;
        state_d    = S_PLACE;
      end
    endcase
  end

  // State, placement flags and registered outputs; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_PLACE;
      placed_a_q <= 1'b0;
      placed_b_q <= 1'b0;
      ldr1a_q    <= 1'b0;
      ldr1b_q    <= 1'b0;
      ldr2a_q    <= 1'b0;
      ldr2b_q    <= 1'b0;
      st_q       <= 1'b0;
      disp_a_q   <= 1'b0;
      disp_b_q   <= 1'b0;
      turn_a_q   <= 1'b0;
      turn_b_q   <= 1'b0;
      clr_game_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      placed_a_q <= placed_a_d;
      placed_b_q <= placed_b_d;
      ldr1a_q    <= ldr1a_d;
      ldr1b_q    <= ldr1b_d;
      ldr2a_q    <= ldr2a_d;
      ldr2b_q    <= ldr2b_d;
      st_q       <= st_of(state_d);
      disp_a_q   <= (state_d == S_WIN_A);
      disp_b_q   <= (state_d == S_WIN_B);
      turn_a_q   <= (state_d == S_TURN_A);
      turn_b_q   <= (state_d == S_TURN_B);
      clr_game_q <= (state_d == S_RESTART);
    end
  end

  assign LDR1A    = ldr1a_q;
  assign LDR1B    = ldr1b_q;
  assign LDR2A    = ldr2a_q;
  assign LDR2B    = ldr2b_q;
  assign ST       = st_q;
  assign DispA    = disp_a_q;
  assign DispB    = disp_b_q;
  assign TurnA    = turn_a_q;
  assign TurnB    = turn_b_q;
  assign clr_game = clr_game_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: two instances (A first, B first) share
// inputs; a phase-level game model predicts every output cycle.
module tb_game_ctrl;

  typedef struct packed {
    logic ldr1a, ldr1b, ldr2a, ldr2b, st, dispa, dispb, turna, turnb, clr_game;
  } out_t;

  typedef struct packed {
    logic clr, b1a, b1b, b2a, b2b, b3a, b3b, oka, okb, liva, livb;
  } in_t;

  // phase: 0 placing, 1 playing, 2 someone won, 3 restarting
  typedef struct {
    int       phase;
    bit       placed_a, placed_b;
    bit       attacker;
    int       step;
    bit       winner;
    bit [5:0] prev;
  } model_t;

  logic clk = 1'b0;
  logic clr, btn1a, btn1b, btn2a, btn2b, btn3a, btn3b, oka, okb, liva, livb;
  logic [9:0] o0, o1;

  in_t    cur;
  model_t m0, m1;
  out_t   q0[$], q1[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;

  always #5 clk = ~clk;

  game_ctrl #(.FIRST_TURN(1'b0)) dut0 (
    .clk(clk), .clr(clr), .BTN1A(btn1a), .BTN1B(btn1b), .BTN2A(btn2a), .BTN2B(btn2b),
    .BTN3A(btn3a), .BTN3B(btn3b), .OKA(oka), .OKB(okb), .LivA(liva), .LivB(livb),
    .LDR1A(o0[9]), .LDR1B(o0[8]), .LDR2A(o0[7]), .LDR2B(o0[6]), .ST(o0[5]),
    .DispA(o0[4]), .DispB(o0[3]), .TurnA(o0[2]), .TurnB(o0[1]), .clr_game(o0[0])
  );

  game_ctrl #(.FIRST_TURN(1'b1)) dut1 (
    .clk(clk), .clr(clr), .BTN1A(btn1a), .BTN1B(btn1b), .BTN2A(btn2a), .BTN2B(btn2b),
    .BTN3A(btn3a), .BTN3B(btn3b), .OKA(oka), .OKB(okb), .LivA(liva), .LivB(livb),
    .LDR1A(o1[9]), .LDR1B(o1[8]), .LDR2A(o1[7]), .LDR2B(o1[6]), .ST(o1[5]),
    .DispA(o1[4]), .DispB(o1[3]), .TurnA(o1[2]), .TurnB(o1[1]), .clr_game(o1[0])
  );

  // One clock of the game as seen from outside: returns the new situation and
  // the outputs expected right after the edge.
  function automatic model_t mstep(input model_t m, input in_t x, input bit ft, output out_t o);
    model_t   n    = m;
    bit [5:0] lvl  = {x.b1a, x.b1b, x.b2a, x.b2b, x.b3a, x.b3b};
    bit [5:0] rise = lvl & ~m.prev;
    n.prev = lvl;
    o = '0;
    if (x.clr) begin
      n.phase = 0; n.placed_a = 1'b0; n.placed_b = 1'b0; n.step = 0;
      o.clr_game = 1'b1;
      return n;
    end
    case (m.phase)
      0: begin
        if (rise[5]) begin o.ldr1a = 1'b1; n.placed_a = 1'b1; end
        if (rise[4]) begin o.ldr1b = 1'b1; n.placed_b = 1'b1; end
        if (n.placed_a && n.placed_b) begin n.phase = 1; n.attacker = ft; n.step = 0; end
      end
      1: begin
        if (m.step == 0) begin
          if (!m.attacker && rise[3] && x.oka) begin o.ldr2a = 1'b1; n.step = 1; end
          if (m.attacker && rise[2] && x.okb) begin o.ldr2b = 1'b1; n.step = 1; end
        end else if (m.step == 1) begin
          if (m.attacker) o.ldr1a = 1'b1; else o.ldr1b = 1'b1;
          n.step = 2;
        end else begin
          if (m.attacker ? x.liva : x.livb) begin n.attacker = !m.attacker; n.step = 0; end
          else begin n.phase = 2; n.winner = m.attacker; end
        end
      end
      2: if (rise[1] || rise[0]) begin n.phase = 3; n.placed_a = 1'b0; n.placed_b = 1'b0; end
      default: n.phase = 0;
    endcase
    o.st       = (n.phase == 1) || (n.phase == 2);
    o.turna    = (n.phase == 1) && (n.step == 0) && !n.attacker;
    o.turnb    = (n.phase == 1) && (n.step == 0) && n.attacker;
    o.dispa    = (n.phase == 2) && !n.winner;
    o.dispb    = (n.phase == 2) && n.winner;
    o.clr_game = (n.phase == 3);
    return n;
  endfunction

  task automatic run(input int n);
    out_t e;
    for (int k = 0; k < n; k++) begin
      clr = cur.clr; btn1a = cur.b1a; btn1b = cur.b1b; btn2a = cur.b2a; btn2b = cur.b2b;
      btn3a = cur.b3a; btn3b = cur.b3b; oka = cur.oka; okb = cur.okb;
      liva = cur.liva; livb = cur.livb;
      @(posedge clk);
      m0 = mstep(m0, cur, 1'b0, e); q0.push_back(e);
      m1 = mstep(m1, cur, 1'b1, e); q1.push_back(e);
      @(negedge clk);
    end
  endtask

  // Monitor: every presented output cycle is checked against the queued expectation.
  always @(negedge clk) begin
    out_t e;
    cyc++;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      n_checks++;
      if (o0 !== e) begin
        n_fail++;
        $display("FAIL outputs_ft0 t=%0t got %b expected %b (ldr1a ldr1b ldr2a ldr2b st dispa dispb turna turnb clr_game)",
                 $time, o0, e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      n_checks++;
      if (o1 !== e) begin
        n_fail++;
        $display("FAIL outputs_ft1 t=%0t got %b expected %b (ldr1a ldr1b ldr2a ldr2b st dispa dispb turna turnb clr_game)",
                 $time, o1, e);
      end
    end
  end

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    cur = '0;
    cur.liva = 1'b1; cur.livb = 1'b1;
    @(negedge clk);

    cur.clr = 1'b1; run(2);
    cur.clr = 1'b0; run(2);

    // A places, B places five cycles later
    cur.b1a = 1'b1; run(1); cur.b1a = 1'b0; run(4);
    cur.b1b = 1'b1; run(1); cur.b1b = 1'b0; run(2);

    // fire without a valid selection, then with one
    cur.oka = 1'b0; cur.b2a = 1'b1; run(1); cur.b2a = 1'b0; run(2);
    cur.oka = 1'b1; cur.b2a = 1'b1; run(1); cur.b2a = 1'b0; run(4);

    // B's shot sinks A's last ship
    cur.liva = 1'b0; cur.okb = 1'b1; cur.b2b = 1'b1; run(1); cur.b2b = 1'b0; run(3);
    for (int i = 0; i < 100; i++) begin
      cur.b2a = i[2]; cur.b2b = i[3];
      run(1);
    end
    cur.b2a = 1'b0; cur.b2b = 1'b0;

    // restart from the win screen
    cur.b3a = 1'b1; run(1); cur.b3a = 1'b0; cur.liva = 1'b1; run(3);

    // simultaneous placement
    cur.b1a = 1'b1; cur.b1b = 1'b1; run(1); cur.b1a = 1'b0; cur.b1b = 1'b0; run(2);

    // clr lands while A's hit is being applied, fire button held throughout
    cur.oka = 1'b1; cur.b2a = 1'b1; run(1);
    cur.clr = 1'b1; run(1);
    cur.clr = 1'b0; run(4);
    cur.b2a = 1'b0; run(2);

    // randomized play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) cur.b1a = !cur.b1a;
      if ($urandom_range(5) == 0) cur.b1b = !cur.b1b;
      if ($urandom_range(3) == 0) cur.b2a = !cur.b2a;
      if ($urandom_range(3) == 0) cur.b2b = !cur.b2b;
      if ($urandom_range(9) == 0) cur.b3a = !cur.b3a;
      if ($urandom_range(9) == 0) cur.b3b = !cur.b3b;
      cur.oka  = ($urandom_range(2) != 0);
      cur.okb  = ($urandom_range(2) != 0);
      cur.liva = ($urandom_range(3) != 0);
      cur.livb = ($urandom_range(3) != 0);
      cur.clr  = ($urandom_range(299) == 0);
      run(1);
    end

    cur = '0;
    run(2);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter: FIRST_TURN, default 0, selects the first attacker after placement (0 = player A, 1 = player B).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 clr  input  1  reset, synchronous and active-high.
REQ-004 BTN1A, BTN1B  input  1 each  ship-placement confirm buttons, debounced and level.
REQ-005 BTN2A, BTN2B  input  1 each  fire buttons, debounced and level.
REQ-006 BTN3A, BTN3B  input  1 each  restart buttons, debounced and level.
REQ-007 OKA, OKB  input  1 each  attack-valid flags: exactly one new position is selected for that player's attack.
REQ-008 LivA, LivB  input  1 each  the player still has at least one unhit ship position.
REQ-009 LDR1A, LDR1B  output  1 each  ship-register load enables.
REQ-010 LDR2A, LDR2B  output  1 each  attack-register load enables.
REQ-011 ST  output  1  ship-register source select (0 = switches, 1 = damage feedback).
REQ-012 DispA, DispB  output  1 each  word select: 1 = win word for that player.
REQ-013 TurnA, TurnB  output  1 each  turn indicator LEDs.
REQ-014 clr_game  output  1  one-cycle datapath clear pulse.

Function
REQ-015 The block SHALL detect a rising edge on each button as a one-cycle pulse, from a registered previous value.
REQ-016 States: PLACE, TURN_A, HIT_A, CHECK_A, TURN_B, HIT_B, CHECK_B, WIN_A, WIN_B, RESTART.
REQ-017 PLACE: ST=0; a BTN1x edge pulses LDR1x for 1 cycle and sets placed_x.
  - Repeat presses reload the ship register and are allowed.
REQ-018 PLACE exits when placed_A and placed_B are both set; next state is TURN_A if FIRST_TURN=0, else TURN_B.
  - Simultaneous BTN1A/BTN1B edges load both registers in the same cycle.
REQ-019 TURN_x: TurnX=1. A BTN2x edge with OKx=1 pulses LDR2x for 1 cycle and moves to HIT_x.
  - A BTN2x edge with OKx=0 is ignored and the state holds.
  - Buttons of the other player are ignored.
REQ-020 HIT_A: ST=1, LDR1B=1 for exactly 1 cycle, applying damage to B; then CHECK_A. HIT_B mirrors this with LDR1A.
REQ-021 CHECK_A: LivB=0 -> WIN_A, else TURN_B. CHECK_B: LivA=0 -> WIN_B, else TURN_A.
  - Latency from the accepted fire edge to the next TURN state is 3 cycles.
REQ-022 WIN_A: DispA=1, DispB=0. WIN_B: the mirror. Each holds until a BTN3A or BTN3B edge.
REQ-023 RESTART: clr_game=1 for 1 cycle; clears placed_A and placed_B; then PLACE.
REQ-024 BTN3 edges outside the WIN states SHALL be ignored.
REQ-025 ST=0 in PLACE and RESTART, and 1 in all other states.
REQ-026 All load-enable outputs SHALL be zero in every cycle not named above; at most one LDR1x and one LDR2x is asserted per cycle, except in the PLACE simultaneous case.
REQ-027 Undefined state encodings SHALL return to PLACE on the next clock.

Reset
REQ-028 clr=1 at a clock edge SHALL force PLACE, clear placed_A and placed_B, and take priority over every event, including mid-turn.
REQ-029 During clr, all outputs SHALL be 0, except clr_game=1.
REQ-030 During clr, the edge-detect previous registers SHALL load the current button levels, so a button held through reset produces no edge.

Structure
REQ-031 The state enum and the FIRST_TURN encodings SHALL live in the shared package game_pkg.
REQ-032 Edge detection SHALL be a single reusable sub-module, edge_detect, instantiated once per button.
REQ-033 Outputs SHALL be decoded from the registered state only (Moore); there are no combinational paths from inputs to outputs.

Verification
REQ-034 Reset, then a BTN1A edge and 5 cycles later a BTN1B edge -> one LDR1A pulse and one LDR1B pulse; TURN_A entered; TurnA=1.
REQ-035 In TURN_A, a BTN2A edge with OKA=0 -> no LDR2A pulse and the state holds. The same edge with OKA=1 -> LDR2A at cycle +1, LDR1B with ST=1 at cycle +2, TurnB=1 at cycle +3.
REQ-036 In CHECK_B with LivA=0 -> WIN_B; DispB=1, DispA=0 stable for 100 cycles; BTN2A/BTN2B edges have no effect.
REQ-037 In WIN_B, a BTN3A edge -> clr_game pulses for 1 cycle; PLACE entered with placed flags cleared and ST=0.
REQ-038 clr asserted in HIT_A with BTN2A held high -> next cycle PLACE with all load enables 0; no edge is detected after clr is released.
REQ-039 FIRST_TURN=1 with simultaneous BTN1A/BTN1B edges -> LDR1A=LDR1B=1 in the same cycle, then TURN_B.
